// File: rtl/min_select_scan.sv
// Chunked minimum finder: scans LANES nodes per cycle and keeps the best unvisited
// node in a running register, with a start/busy/done handshake.

module min_select_lane #(
    parameter int   INDEX_WIDTH = 6,
    parameter int   VALUE_WIDTH = 32,
    parameter int   LANES       = 8,
    parameter int   LANE        = 0,
    parameter int   CW          = 3,
    parameter int   NW          = 6,
    parameter int   PAD         = 64,
    parameter logic UNVISITED   = 1'b0
) (
    input  logic [CW-1:0]                     chunk_i,
    input  logic [PAD-1:0]                    vis_i,
    input  logic [PAD-1:0][VALUE_WIDTH-1:0]   dist_i,
    output logic                              vld_o,
    output logic [VALUE_WIDTH-1:0]            val_o,
    output logic [INDEX_WIDTH-1:0]            idx_o
);
    logic [NW-1:0] node;

    assign node  = NW'(int'(chunk_i) * LANES + LANE);
    assign vld_o = (vis_i[node] == UNVISITED);
    assign val_o = dist_i[node];
    assign idx_o = INDEX_WIDTH'(node);
endmodule

module min_select_scan #(
    parameter int   MAX_NODES   = 64,
    parameter int   INDEX_WIDTH = 6,
    parameter int   VALUE_WIDTH = 32,
    parameter int   LANES       = 8,
    parameter logic UNVISITED   = 1'b0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [MAX_NODES-1:0]             visited_vector,
    input  logic [MAX_NODES*VALUE_WIDTH-1:0] dist_vector,
    output logic                             busy,
    output logic                             done,
    output logic [INDEX_WIDTH-1:0]           min_index,
    output logic [VALUE_WIDTH-1:0]           min_value,
    output logic                             min_found
);
    localparam int CHUNKS = (MAX_NODES + LANES - 1) / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int NW     = (CHUNKS * LANES > 1) ? $clog2(CHUNKS * LANES) : 1;
    localparam int PAD    = 2 ** NW;
    localparam int P      = 2 ** $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef struct packed {
        logic                   vld;
        logic [VALUE_WIDTH-1:0] val;
        logic [INDEX_WIDTH-1:0] idx;
    } cand_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // a always holds the lower node indices, so it keeps ties
    function automatic cand_t pick(input cand_t a, input cand_t b);
        if (!b.vld) return a;
        if (!a.vld) return b;
        return (b.val < a.val) ? b : a;
    endfunction

    state_t                          state_q;
    logic [CW-1:0]                   chunk_q;
    cand_t                           best_q, best_d;
    logic                            done_q;
    logic [INDEX_WIDTH-1:0]          idx_q;
    logic [VALUE_WIDTH-1:0]          val_q;
    logic                            found_q;

    logic [PAD-1:0]                  vis_pad;
    logic [PAD-1:0][VALUE_WIDTH-1:0] dist_pad;
    logic [P-1:0]                    leaf_vld;
    logic [P-1:0][VALUE_WIDTH-1:0]   leaf_val;
    logic [P-1:0][INDEX_WIDTH-1:0]   leaf_idx;
    cand_t                           tree [2*P-1];

    // Nodes past MAX_NODES read as visited so a partial last chunk never wins
    for (genvar k = 0; k < PAD; k++) begin : g_pad
        if (k < MAX_NODES) begin : g_real
            assign vis_pad[k]  = visited_vector[k];
            assign dist_pad[k] = dist_vector[k*VALUE_WIDTH +: VALUE_WIDTH];
        end else begin : g_fill
            assign vis_pad[k]  = ~UNVISITED;
            assign dist_pad[k] = '0;
        end
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        if (l < LANES) begin : g_act
            min_select_lane #(
                .INDEX_WIDTH(INDEX_WIDTH), .VALUE_WIDTH(VALUE_WIDTH), .LANES(LANES),
                .LANE(l), .CW(CW), .NW(NW), .PAD(PAD), .UNVISITED(UNVISITED)
            ) u_lane (
                .chunk_i (chunk_q),
                .vis_i   (vis_pad),
                .dist_i  (dist_pad),
                .vld_o   (leaf_vld[l]),
                .val_o   (leaf_val[l]),
                .idx_o   (leaf_idx[l])
            );
        end else begin : g_idle
            assign leaf_vld[l] = 1'b0;
            assign leaf_val[l] = '0;
            assign leaf_idx[l] = '0;
        end
    end

    // Heap-ordered reduction tree: root at 0, leaves at P-1 .. 2P-2
    always_comb begin
        for (int i = 0; i < 2*P-1; i++) tree[i] = '0;
        for (int l = 0; l < P; l++) begin
            tree[P-1+l].vld = leaf_vld[l];
            tree[P-1+l].val = leaf_val[l];
            tree[P-1+l].idx = leaf_idx[l];
        end
        for (int i = P-2; i >= 0; i--) tree[i] = pick(tree[2*i+1], tree[2*i+2]);
    end

    assign best_d = pick(best_q, tree[0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            chunk_q <= '0;
            best_q  <= '0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            val_q   <= '0;
            found_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SCAN;
                    chunk_q <= '0;
                    best_q  <= '0;
                end
                SCAN: begin
                    best_q <= best_d;
                    if (chunk_q == LAST) state_q <= DONE;
                    else                 chunk_q <= chunk_q + 1'b1;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    found_q <= best_q.vld;
                    idx_q   <= best_q.vld ? best_q.idx : '0;
                    val_q   <= best_q.vld ? best_q.val : '0;
                    chunk_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = done_q;
    assign min_index = idx_q;
    assign min_value = val_q;
    assign min_found = found_q;
endmodule

// File: tb/tb_min_select_scan.sv
// Directed bench for min_select_scan: an 8-node/4-lane and a 6-node/4-lane instance,
// expected results come from a reference model through a scoreboard queue.

module tb_min_select_scan;
    localparam logic [31:0] F05 = 32'h3F000000, F1 = 32'h3F800000, F2 = 32'h40000000,
                            F3 = 32'h40400000, F4 = 32'h40800000, F5 = 32'h40A00000,
                            F6 = 32'h40C00000, F7 = 32'h40E00000, F8 = 32'h41000000,
                            F9 = 32'h41100000, FINF = 32'h7F800000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            st8, st6;
    logic [7:0]      vis8;
    logic [5:0]      vis6;
    logic [7:0][31:0] dv8;
    logic [5:0][31:0] dv6;
    logic            busy8, done8, fnd8, busy6, done6, fnd6;
    logic [2:0]      idx8, idx6;
    logic [31:0]     val8, val6;

    min_select_scan #(.MAX_NODES(8), .INDEX_WIDTH(3), .VALUE_WIDTH(32), .LANES(4), .UNVISITED(1'b0)) u8 (
        .clock(clk), .reset(rst), .start(st8), .visited_vector(vis8), .dist_vector(dv8),
        .busy(busy8), .done(done8), .min_index(idx8), .min_value(val8), .min_found(fnd8));

    min_select_scan #(.MAX_NODES(6), .INDEX_WIDTH(3), .VALUE_WIDTH(32), .LANES(4), .UNVISITED(1'b0)) u6 (
        .clock(clk), .reset(rst), .start(st6), .visited_vector(vis6), .dist_vector(dv6),
        .busy(busy6), .done(done6), .min_index(idx6), .min_value(val6), .min_found(fnd6));

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] val;
        logic        fnd;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Linear scan, strict less-than keeps the lowest index on ties
    function automatic exp_t model(input logic [7:0][31:0] d, input logic [7:0] v, input int n);
        exp_t e;
        e.idx = '0; e.val = '0; e.fnd = 1'b0;
        for (int k = 0; k < n; k++)
            if (v[k] == 1'b0 && (!e.fnd || d[k] < e.val)) begin
                e.fnd = 1'b1; e.val = d[k]; e.idx = 3'(k);
            end
        return e;
    endfunction

    function automatic exp_t model_of(input bit sel);
        if (sel) return model({64'h0, dv6}, {2'b11, vis6}, 6);
        return model(dv8, vis8, 8);
    endfunction

    task automatic check_result(input string tag, input bit sel);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "/idx"},   32'(sel ? idx6 : idx8), 32'(e.idx));
        chk({tag, "/val"},   sel ? val6 : val8,      e.val);
        chk({tag, "/found"}, 32'(sel ? fnd6 : fnd8), 32'(e.fnd));
    endtask

    // One start pulse; k counts edges after the start edge, done expected at k=3
    task automatic scan(input bit sel, input string tag);
        int k;
        sb.push_back(model_of(sel));
        @(negedge clk);
        if (sel) st6 = 1'b1; else st8 = 1'b1;
        @(negedge clk);
        st6 = 1'b0; st8 = 1'b0;
        chk({tag, "/busy"}, 32'(sel ? busy6 : busy8), 32'd1);
        k = 0;
        while (!(sel ? done6 : done8) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/latency"}, 32'(k), 32'd3);
        check_result(tag, sel);
        @(negedge clk);
        chk({tag, "/done_drop"}, 32'(sel ? done6 : done8), 32'd0);
        chk({tag, "/idle"},      32'(sel ? busy6 : busy8), 32'd0);
    endtask

    task automatic load_s1();
        dv8[0] = F5; dv8[1] = F3; dv8[2] = F7; dv8[3] = F1;
        dv8[4] = F9; dv8[5] = F2; dv8[6] = F4; dv8[7] = F6;
        vis8 = '0;
    endtask

    initial begin
        int pulses, first_k, second_k;
        rst = 1'b1; st8 = 1'b0; st6 = 1'b0;
        vis8 = '0; vis6 = '0; dv8 = '0; dv6 = '0;
        repeat (2) @(negedge clk);
        chk("reset/busy",  32'(busy8), 32'd0);
        chk("reset/done",  32'(done8), 32'd0);
        chk("reset/idx",   32'(idx8),  32'd0);
        chk("reset/val",   val8,       32'd0);
        chk("reset/found", 32'(fnd8),  32'd0);
        rst = 1'b0;

        load_s1();
        scan(0, "s1");
        chk("s1/idx_abs", 32'(idx8), 32'd3);
        chk("s1/val_abs", val8, F1);

        vis8[3] = 1'b1; vis8[5] = 1'b1;
        scan(0, "s2");
        chk("s2/idx_abs", 32'(idx8), 32'd1);

        for (int k = 0; k < 8; k++) dv8[k] = F8;
        dv8[2] = F1; dv8[6] = F1; vis8 = '0;
        scan(0, "s3_tie");
        chk("s3/idx_abs", 32'(idx8), 32'd2);
        vis8[2] = 1'b1;
        scan(0, "s3_tie_vis");
        chk("s3b/idx_abs", 32'(idx8), 32'd6);

        vis8 = '1;
        scan(0, "s4_allvis");
        chk("s4/found_abs", 32'(fnd8), 32'd0);
        for (int k = 0; k < 8; k++) dv8[k] = FINF;
        vis8 = '0;
        scan(0, "s4_inf");
        chk("s4b/val_abs", val8, FINF);

        // Padded lanes plus a second start during SCAN
        for (int k = 0; k < 6; k++) dv6[k] = F8;
        dv6[5] = F05; vis6 = '0;
        sb.push_back(model_of(1));
        @(negedge clk); st6 = 1'b1;
        @(negedge clk);
        pulses = 0; first_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) st6 = 1'b0;
            if (done6) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    check_result("s5", 1);
                end
            end
            @(negedge clk);
        end
        st6 = 1'b0;
        chk("s5/latency", 32'(first_k), 32'd3);
        chk("s5/pulses",  32'(pulses),  32'd1);
        chk("s5/idx_abs", 32'(idx6), 32'd5);
        vis6[5] = 1'b1; dv6[1] = F3;
        scan(1, "s5_vis");

        // Reset in the second SCAN cycle
        load_s1();
        @(negedge clk); st8 = 1'b1;
        @(negedge clk); st8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6/busy",  32'(busy8), 32'd0);
        chk("s6/done",  32'(done8), 32'd0);
        chk("s6/idx",   32'(idx8),  32'd0);
        chk("s6/val",   val8,       32'd0);
        chk("s6/found", 32'(fnd8),  32'd0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("s6/no_done", 32'(pulses), 32'd0);
        scan(0, "s6_fresh");

        // Start held high: a new scan every CHUNKS+2 cycles
        @(negedge clk); st8 = 1'b1;
        first_k = -1; second_k = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) begin
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
        end
        st8 = 1'b0;
        chk("cont/period", 32'(second_k - first_k), 32'd4);
        repeat (8) @(negedge clk);
        chk("cont/idle", 32'(busy8), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/min_select_scan.md
Name: min_select_scan

Overview:
- Parametrised successor to the Dijkstra min-finder.
- Each cycle, compares a LANES-wide slice of the distance/visited vectors and keeps the best unvisited node in a running register, so comparator cost scales with LANES, not MAX_NODES.
- Uses an explicit start/busy/done handshake in place of fixed wait-cycle counting and clock division, and reports an explicit "no unvisited node" result.
- Sits between the distance register file and the Dijkstra relaxation controller; single clock domain.

Parameters:
- MAX_NODES, 64, number of graph nodes scanned.
- INDEX_WIDTH, 6, width of a node index; must satisfy 2**INDEX_WIDTH >= MAX_NODES.
- VALUE_WIDTH, 32, distance width; IEEE-754 single precision, non-negative.
- LANES, 8, nodes compared per scan cycle; 1 <= LANES <= MAX_NODES; MAX_NODES need not be a multiple of LANES.
- UNVISITED, 1'b0, visited_vector bit value meaning "not yet visited".

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request a new scan; sampled only in IDLE.
- visited_vector  in  MAX_NODES  per-node visited flags.
- dist_vector  in  MAX_NODES*VALUE_WIDTH  flattened distances; node k occupies bits [k*VALUE_WIDTH +: VALUE_WIDTH].
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse; result outputs valid.
- min_index  out  INDEX_WIDTH  index of the minimum unvisited node.
- min_value  out  VALUE_WIDTH  distance of min_index.
- min_found  out  1  1 if at least one unvisited node existed.

Behaviour:
- Reset values: busy=0, done=0, min_index=0, min_value=0, min_found=0, FSM=IDLE, chunk counter=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN when start=1. The running best is cleared to "none" and the chunk counter set to 0.
- SCAN: each cycle, chunk c (nodes c*LANES .. c*LANES+LANES-1) is reduced by a combinational LANES-input tree and merged with the running best.
  - Let C = ceil(MAX_NODES/LANES). After chunk C-1 the FSM moves to DONE.
  - Lanes with index >= MAX_NODES are treated as visited.
- DONE: done=1 for exactly one cycle. Outputs are registered with the final best. Then the FSM returns to IDLE.
- Latency: start sampled at edge 0; done high in the cycle after edge C+1. With MAX_NODES=8 and LANES=4: start at edge 0, done visible after edge 3.
- Outputs hold their last result until the next DONE. They are not cleared by a new start.
- Compare rule: non-negative floats are compared as unsigned VALUE_WIDTH integers. +inf (0x7F800000) is a legal distance and loses to any finite value.
- Tie rule: equal values resolve to the lower index, both within a chunk and across chunks (the running best wins ties).
- A node participates only if its visited bit equals UNVISITED.
- All nodes visited: min_found=0, min_index=0, min_value=0.
- start while in SCAN or DONE is ignored. No queuing.
- Inputs must remain stable from start until done. Changes mid-scan give undefined results but must not hang the FSM.
- Reset asserted mid-scan: immediate return to IDLE with reset values. No done pulse is generated.
- start held high continuously: a new scan begins every C+2 cycles (IDLE -> SCAN -> DONE -> IDLE).

Test Plan:
1. MAX_NODES=8, LANES=4. dist = {5.0, 3.0, 7.0, 1.0, 9.0, 2.0, 4.0, 6.0}, none visited. Pulse start -> done after edge 3; min_index=3, min_value=0x3F800000, min_found=1.
2. Same distances, nodes 3 and 5 visited -> min_index=1, min_value=0x40400000 (3.0).
3. Tie: node 2 = node 6 = 1.0, all others 8.0, none visited -> min_index=2. Repeat with node 2 visited -> min_index=6.
4. All nodes visited -> done pulse; min_found=0, min_index=0, min_value=0. Also: all distances +inf, none visited -> min_index=0, min_value=0x7F800000, min_found=1.
5. MAX_NODES=6, LANES=4 (padded lanes). Minimum at node 5 = 0.5 -> min_index=5; done after edge 3. A second start asserted during SCAN is ignored (exactly one done pulse).
6. Assert reset during the second SCAN cycle -> busy and done drop asynchronously, outputs read 0, no done pulse. A fresh start afterwards yields the correct result from scenario 1.
